sme_job_sequencer: RTL

Sequences jobs through one string-matching engine (SME core). A job is one string followed by 1..NUM_PAT patterns. The block buffers the whole job from a valid/ready host stream, then replays it to the engine in the engine's native protocol. The string is sent once; each pattern is sent in turn. For every pattern it waits for the engine verdict and emits one tagged result on a valid/ready output stream.

---
 rtl/sme_pkg.sv | 42 ++++
 rtl/sme_job_buffer.sv | 101 ++++++++++
 rtl/sme_job_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sme_pkg.sv
// Shared types and constants for the SME job sequencer: FSM states, sizes,
// result payload and the special characters understood by the engine.
package sme_pkg;

  localparam int unsigned MAX_STR = 32;
  localparam int unsigned MAX_PAT = 8;
  localparam int unsigned NUM_PAT = 4;
  localparam int unsigned TIMEOUT = 255;

  localparam int unsigned STR_IW = $clog2(MAX_STR);
  localparam int unsigned PAT_IW = $clog2(MAX_PAT);
  localparam int unsigned PID_W  = $clog2(NUM_PAT);
  // Length/count registers must hold the saturated maximum itself.
  localparam int unsigned SLEN_W = STR_IW + 1;
  localparam int unsigned PLEN_W = PAT_IW + 1;
  localparam int unsigned NPAT_W = PID_W + 1;
  localparam int unsigned WD_W   = 8;

  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_STAR   = 8'h2A;

  typedef enum logic [2:0] {
    LD_STR,
    LD_PAT,
    SEND_STR,
    SEND_PAT,
    WAIT,
    EMIT
  } state_e;

  typedef struct packed {
    logic              match;
    logic [STR_IW-1:0] index;
    logic [PID_W-1:0]  pid;
    logic              timeout;
    logic              trunc;
  } result_t;

endpackage

// File: rtl/sme_job_buffer.sv
// Job storage: one string and up to NUM_PAT patterns with saturating lengths,
// truncation flags and a combinational read port addressed by (kind, slot, k).
module sme_job_buffer
  import sme_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              wr_str_i,
  input  logic              wr_pat_i,
  input  logic              wr_last_i,
  input  logic [7:0]        wr_data_i,
  input  logic              rd_kind_i,
  input  logic [PID_W-1:0]  rd_slot_i,
  input  logic [STR_IW-1:0] rd_k_i,
  output logic [7:0]        rd_data_c,
  input  logic [PID_W-1:0]  sel_slot_i,
  output logic [PLEN_W-1:0] sel_plen_c,
  output logic              sel_trunc_c,
  output logic [SLEN_W-1:0] slen_o,
  output logic [NPAT_W-1:0] npat_o,
  output logic              str_trunc_o
);

  logic [7:0]        str_mem [MAX_STR];
  logic [7:0]        pat_mem [NUM_PAT][MAX_PAT];

  logic [SLEN_W-1:0] slen_q, slen_d;
  logic [PLEN_W-1:0] plen_q [NUM_PAT];
  logic [PLEN_W-1:0] plen_d [NUM_PAT];
  logic [NPAT_W-1:0] npat_q, npat_d;
  logic              str_trunc_q, str_trunc_d;
  logic [NUM_PAT-1:0] ptrunc_q, ptrunc_d;

  logic              slot_ok;
  logic [PID_W-1:0]  wslot;
  logic              str_wr_en;
  logic              pat_wr_en;

  // Patterns past the last slot are dropped entirely, including their flags.
  assign slot_ok   = npat_q < NPAT_W'(NUM_PAT);
  assign wslot     = PID_W'(npat_q);
  assign str_wr_en = wr_str_i && (slen_q < SLEN_W'(MAX_STR));
  assign pat_wr_en = wr_pat_i && slot_ok && (plen_q[wslot] < PLEN_W'(MAX_PAT));

  always_comb begin
    slen_d      = slen_q;
    plen_d      = plen_q;
    npat_d      = npat_q;
    str_trunc_d = str_trunc_q;
    ptrunc_d    = ptrunc_q;
    if (clear_i) begin
      slen_d      = '0;
      plen_d      = '{default: '0};
      npat_d      = '0;
      str_trunc_d = 1'b0;
      ptrunc_d    = '0;
    end else begin
      if (wr_str_i) begin
        if (str_wr_en) slen_d = slen_q + SLEN_W'(1);
        else           str_trunc_d = 1'b1;
      end
      if (wr_pat_i && slot_ok) begin
        if (pat_wr_en) plen_d[wslot] = plen_q[wslot] + PLEN_W'(1);
        else           ptrunc_d[wslot] = 1'b1;
        if (wr_last_i) npat_d = npat_q + NPAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slen_q      <= '0;
      plen_q      <= '{default: '0};
      npat_q      <= '0;
      str_trunc_q <= 1'b0;
      ptrunc_q    <= '0;
    end else begin
      slen_q      <= slen_d;
      plen_q      <= plen_d;
      npat_q      <= npat_d;
      str_trunc_q <= str_trunc_d;
      ptrunc_q    <= ptrunc_d;
    end
  end

  // Character storage carries no reset; lengths gate every read.
  always_ff @(posedge clk) begin
    if (str_wr_en) str_mem[slen_q[STR_IW-1:0]] <= wr_data_i;
    if (pat_wr_en) pat_mem[wslot][plen_q[wslot][PAT_IW-1:0]] <= wr_data_i;
  end

  assign rd_data_c   = rd_kind_i ? pat_mem[rd_slot_i][rd_k_i[PAT_IW-1:0]]
                                 : str_mem[rd_k_i];
  assign sel_plen_c  = plen_q[sel_slot_i];
  assign sel_trunc_c = ptrunc_q[sel_slot_i];
  assign slen_o      = slen_q;
  assign npat_o      = npat_q;
  assign str_trunc_o = str_trunc_q;

endmodule

// File: rtl/sme_job_sequencer.sv
// Buffers a string-matching job from the host, replays it to the SME engine
// one pattern at a time and emits one tagged result per pattern.
module sme_job_sequencer
  import sme_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_kind,
  input  logic              in_last,
  input  logic              in_eoj,
  output logic [7:0]        eng_chardata,
  output logic              eng_isstring,
  output logic              eng_ispattern,
  input  logic              eng_valid,
  input  logic              eng_match,
  input  logic [STR_IW-1:0] eng_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_match,
  output logic [STR_IW-1:0] out_index,
  output logic [PID_W-1:0]  out_pid,
  output logic              out_timeout,
  output logic              out_trunc,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [STR_IW-1:0] k_q, k_d;
  logic [PID_W-1:0]  p_q, p_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  result_t           res_q, res_d;

  logic [7:0]        eng_char_q, eng_char_d;
  logic              eng_isstring_q, eng_isstring_d;
  logic              eng_ispattern_q, eng_ispattern_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic              in_fire;
  logic              wr_str, wr_pat;
  logic              clear;
  logic [SLEN_W-1:0] k_inc;
  logic [7:0]        rd_data;
  logic [PLEN_W-1:0] sel_plen;
  logic              sel_trunc;
  logic [SLEN_W-1:0] slen;
  logic [NPAT_W-1:0] npat;
  logic              str_trunc;

  assign in_ready = (state_q == LD_STR) || (state_q == LD_PAT);
  assign in_fire  = in_valid && in_ready;
  assign wr_str   = in_fire && !in_kind && (state_q == LD_STR);
  assign wr_pat   = in_fire && in_kind && (state_q == LD_PAT);
  assign k_inc    = SLEN_W'(k_q) + SLEN_W'(1);

  sme_job_buffer u_buf (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (clear),
    .wr_str_i    (wr_str),
    .wr_pat_i    (wr_pat),
    .wr_last_i   (in_last),
    .wr_data_i   (in_data),
    .rd_kind_i   (state_d == SEND_PAT),
    .rd_slot_i   (p_d),
    .rd_k_i      (k_d),
    .rd_data_c   (rd_data),
    .sel_slot_i  (p_q),
    .sel_plen_c  (sel_plen),
    .sel_trunc_c (sel_trunc),
    .slen_o      (slen),
    .npat_o      (npat),
    .str_trunc_o (str_trunc)
  );

  // Next-state logic: load, replay string, replay pattern, wait, emit.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    p_d     = p_q;
    wd_d    = wd_q;
    res_d   = res_q;
    clear   = 1'b0;
    case (state_q)
      LD_STR: begin
        if (wr_str && in_last) state_d = LD_PAT;
      end
      LD_PAT: begin
        if (wr_pat && in_last && in_eoj) begin
          state_d = SEND_STR;
          k_d     = '0;
          p_d     = '0;
        end
      end
      SEND_STR: begin
        if (k_inc >= slen) begin
          state_d = SEND_PAT;
          k_d     = '0;
        end else begin
          k_d = k_q + STR_IW'(1);
        end
      end
      SEND_PAT: begin
        if (k_inc >= SLEN_W'(sel_plen)) begin
          state_d = WAIT;
          k_d     = '0;
          wd_d    = '0;
        end else begin
          k_d = k_q + STR_IW'(1);
        end
      end
      WAIT: begin
        wd_d        = wd_q + WD_W'(1);
        res_d.pid   = p_q;
        res_d.trunc = str_trunc | sel_trunc;
        // A verdict arriving on the expiry cycle still wins.
        if (eng_valid) begin
          res_d.match   = eng_match;
          res_d.index   = eng_index;
          res_d.timeout = 1'b0;
          state_d       = EMIT;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          res_d.match   = 1'b0;
          res_d.index   = '0;
          res_d.timeout = 1'b1;
          state_d       = EMIT;
        end else begin
          res_d = res_q;
        end
      end
      EMIT: begin
        if (out_ready && out_valid_q) begin
          if ((NPAT_W'(p_q) + NPAT_W'(1)) < npat) begin
            p_d     = p_q + PID_W'(1);
            k_d     = '0;
            state_d = SEND_PAT;
          end else begin
            p_d     = '0;
            k_d     = '0;
            clear   = 1'b1;
            state_d = LD_STR;
          end
        end
      end
      default: state_d = LD_STR;
    endcase
  end

  // Registered outputs follow the next state so they line up with it.
  always_comb begin
    eng_isstring_d  = (state_d == SEND_STR);
    eng_ispattern_d = (state_d == SEND_PAT);
    eng_char_d      = (eng_isstring_d || eng_ispattern_d) ? rd_data : 8'h00;
    out_valid_d     = (state_d == EMIT);
    busy_d          = (state_d != LD_STR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= LD_STR;
      k_q             <= '0;
      p_q             <= '0;
      wd_q            <= '0;
      res_q           <= '0;
      eng_char_q      <= '0;
      eng_isstring_q  <= 1'b0;
      eng_ispattern_q <= 1'b0;
      out_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      k_q             <= k_d;
      p_q             <= p_d;
      wd_q            <= wd_d;
      res_q           <= res_d;
      eng_char_q      <= eng_char_d;
      eng_isstring_q  <= eng_isstring_d;
      eng_ispattern_q <= eng_ispattern_d;
      out_valid_q     <= out_valid_d;
      busy_q          <= busy_d;
    end
  end

  assign eng_chardata  = eng_char_q;
  assign eng_isstring  = eng_isstring_q;
  assign eng_ispattern = eng_ispattern_q;
  assign out_valid     = out_valid_q;
  assign out_match     = res_q.match;
  assign out_index     = res_q.index;
  assign out_pid       = res_q.pid;
  assign out_timeout   = res_q.timeout;
  assign out_trunc     = res_q.trunc;
  assign busy          = busy_q;

endmodule
